// File: rtl/cfo_est_sequencer.sv
// Drives the CFO estimator go/End/done handshake for 2^LOG2_AVG back-to-back runs.
// It then presents the arithmetic-shift average of the captured estimates; every wait is bounded by TIMEOUT.
module cfo_est_sequencer #(
    parameter int EW       = 16,
    parameter int LOG2_AVG = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          go,
    input  logic          t_valid,
    input  logic [EW-1:0] est_in,
    output logic          est_end,
    input  logic          done_in,
    output logic [EW-1:0] est_out,
    output logic          est_valid,
    output logic          timeout_err,
    output logic          busy
);

    localparam int AW = EW + LOG2_AVG;
    localparam int RW = (LOG2_AVG < 1) ? 1 : LOG2_AVG;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'((1 << LOG2_AVG) - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_GO, S_WAIT_T, S_END, S_WAIT_DONE, S_OUT, S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [RW-1:0]        run_q, run_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [EW-1:0]        est_out_q, est_out_d;
    logic                 go_q, go_d;
    logic                 est_end_q, est_end_d;
    logic                 est_valid_q, est_valid_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 busy_q, busy_d;
    logic signed [AW-1:0] est_sext;

    assign est_sext = AW'(signed'(est_in));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        run_d     = run_q;
        timer_d   = timer_q;
        est_out_d = est_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_GO;
                    acc_d   = '0;
                    run_d   = '0;
                end
            end
            S_GO: begin
                state_d = S_WAIT_T;
                timer_d = '0;
            end
            S_WAIT_T: begin
                // An estimate arriving on the last permitted cycle still wins over the timeout.
                if (t_valid) begin
                    acc_d   = acc_q + est_sext;
                    state_d = S_END;
                end else if (timer_q == TIMER_MAX) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_END: begin
                state_d = S_WAIT_DONE;
                timer_d = '0;
            end
            S_WAIT_DONE: begin
                if (done_in) begin
                    if (run_q == RUN_LAST) begin
                        state_d   = S_OUT;
                        est_out_d = EW'(acc_q >>> LOG2_AVG);
                    end else begin
                        run_d   = run_q + 1'b1;
                        state_d = S_GO;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_OUT:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of the next-state decode, so they line up with state_q.
        go_d          = (state_d == S_GO);
        est_end_d     = (state_d == S_END);
        est_valid_d   = (state_d == S_OUT);
        timeout_err_d = (state_d == S_ERR);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            run_q         <= '0;
            timer_q       <= '0;
            est_out_q     <= '0;
            go_q          <= 1'b0;
            est_end_q     <= 1'b0;
            est_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            run_q         <= run_d;
            timer_q       <= timer_d;
            est_out_q     <= est_out_d;
            go_q          <= go_d;
            est_end_q     <= est_end_d;
            est_valid_q   <= est_valid_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign go          = go_q;
    assign est_end     = est_end_q;
    assign est_out     = est_out_q;
    assign est_valid   = est_valid_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule
